// File: rtl/p2s_rr_scheduler_if.sv
// Request/serial-output bundle for p2s_rr_scheduler.
// slave  : scheduler side (takes requests, drives the serial frame)
// master : producer/link side (drives requests, observes the frame)
interface p2s_rr_scheduler_if #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    parameter int CHW  = 2
) ();
    logic [N_CH-1:0]    req_valid;
    logic [N_CH*DW-1:0] req_data;
    logic [N_CH-1:0]    req_ready;
    logic               dout_serial;
    logic               dout_valid;
    logic               dout_last;
    logic [CHW-1:0]     dout_chan;
    logic               busy;

    modport slave (
        input  req_valid, req_data,
        output req_ready, dout_serial, dout_valid, dout_last, dout_chan, busy
    );

    modport master (
        output req_valid, req_data,
        input  req_ready, dout_serial, dout_valid, dout_last, dout_chan, busy
    );
endinterface

// File: rtl/p2s_rr_scheduler.sv
// Round-robin scheduler sharing one parallel-to-serial shifter between
// N_CH requesters. One frame per grant, MSB first, tagged with channel
// and a last-bit marker.
// Optional macro P2S_PARITY_EN appends an even-parity bit to each frame.
module p2s_rr_scheduler #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    parameter int CHW  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    p2s_rr_scheduler_if.slave     bus
);

`ifdef P2S_PARITY_EN
    localparam int FRAME = DW + 1;
`else
    localparam int FRAME = DW;
`endif
    localparam int CNTW = $clog2(DW + 1);

    localparam logic [CNTW-1:0] LAST_CNT     = CNTW'(FRAME - 1);
    localparam logic [CNTW-1:0] PRE_LAST_CNT = CNTW'(FRAME - 2);
    localparam logic [CHW-1:0]  LAST_CH      = CHW'(N_CH - 1);
`ifdef P2S_PARITY_EN
    localparam logic [CNTW-1:0] LAST_DATA_CNT = CNTW'(DW - 1);
`endif

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CNTW-1:0] r_cnt;
    logic [CHW-1:0]  r_ptr;
    logic [DW-1:0]   r_shift;
    logic            r_dout_serial;
    logic            r_dout_valid;
    logic            r_dout_last;
    logic [CHW-1:0]  r_dout_chan;
`ifdef P2S_PARITY_EN
    logic            r_parity;
`endif

    logic [DW-1:0]   w_word [N_CH];
    logic            w_last_bit;
    logic            w_window;
    logic            w_grant_any;
    logic [CHW-1:0]  w_grant_idx;
    logic            w_xfer;
    logic [N_CH-1:0] w_ready;

    // Unpack the flattened request words per channel
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_word
            assign w_word[gi] = bus.req_data[gi*DW +: DW];
        end
    endgenerate

    // The final bit of a frame doubles as the accept slot for the next one
    assign w_last_bit = (r_state == SHIFT) && (r_cnt == LAST_CNT);
    assign w_window   = (r_state == IDLE) || w_last_bit;

    // Round-robin search: first valid channel at or after the pointer, with wrap.
    // Iterating from the farthest offset down lets the nearest one win.
    always_comb begin
        int cand;
        cand        = 0;
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            cand = int'(r_ptr) + i;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end
            if (bus.req_valid[CHW'(cand)]) begin
                w_grant_any = 1'b1;
                w_grant_idx = CHW'(cand);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: stay in SHIFT across back-to-back grants
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_xfer) w_state_next = SHIFT;
            SHIFT:   if (w_last_bit && !w_xfer) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Output logic: a transfer happens whenever the window is open and someone asks
    always_comb begin
        w_xfer = w_window && w_grant_any;
    end

    // One-hot ready toward the granted channel only
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
            assign w_ready[gi] = w_xfer && (w_grant_idx == CHW'(gi));
        end
    endgenerate

    // Datapath: capture on handshake, then step one bit per cycle.
    // r_shift keeps the not-yet-sent bits MSB-aligned; the first bit goes
    // straight to the output register on the capture edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_ptr         <= '0;
            r_shift       <= '0;
            r_dout_serial <= 1'b0;
            r_dout_valid  <= 1'b0;
            r_dout_last   <= 1'b0;
            r_dout_chan   <= '0;
`ifdef P2S_PARITY_EN
            r_parity      <= 1'b0;
`endif
        end else if (w_xfer) begin
            r_shift       <= {w_word[w_grant_idx][DW-2:0], 1'b0};
            r_dout_serial <= w_word[w_grant_idx][DW-1];
            r_dout_valid  <= 1'b1;
            r_dout_last   <= 1'b0;
            r_dout_chan   <= w_grant_idx;
            r_ptr         <= (w_grant_idx == LAST_CH) ? '0 : w_grant_idx + 1'b1;
            r_cnt         <= '0;
`ifdef P2S_PARITY_EN
            r_parity      <= ^w_word[w_grant_idx];
`endif
        end else if (r_state == SHIFT) begin
            if (w_last_bit) begin
                r_dout_serial <= 1'b0;
                r_dout_valid  <= 1'b0;
                r_dout_last   <= 1'b0;
                r_cnt         <= '0;
            end else begin
                r_cnt       <= r_cnt + 1'b1;
                r_shift     <= {r_shift[DW-2:0], 1'b0};
                r_dout_last <= (r_cnt == PRE_LAST_CNT);
`ifdef P2S_PARITY_EN
                r_dout_serial <= (r_cnt == LAST_DATA_CNT) ? r_parity : r_shift[DW-1];
`else
                r_dout_serial <= r_shift[DW-1];
`endif
            end
        end
    end

    assign bus.req_ready   = w_ready;
    assign bus.dout_serial = r_dout_serial;
    assign bus.dout_valid  = r_dout_valid;
    assign bus.dout_last   = r_dout_last;
    assign bus.dout_chan   = r_dout_chan;
    assign bus.busy        = (r_state == SHIFT);

endmodule

// File: doc/p2s_rr_scheduler.md
Name: p2s_rr_scheduler

Overview:
- Round-robin scheduler that shares one parallel-to-serial shifter between N_CH byte-wide requesters.
- Each requester presents a parallel word with a valid/ready handshake.
- The block grants one requester per frame, captures its word, and shifts it out MSB-first on a single serial line.
- Each frame is tagged with the source channel and a last-bit marker.
- Sits between the per-channel data producers and the serial link driver.

Parameters:
N_CH, 4, number of requesters (2..8)
DW, 8, parallel word width in bits (2..16)
CHW, 2, width of channel index; must be ≥ clog2(N_CH), min 1

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  N_CH  per-channel word valid
req_data  input  N_CH*DW  flattened words; channel i at [i*DW +: DW]
req_ready  output  N_CH  per-channel accept, one-hot or zero (combinational)
dout_serial  output  1  serial data bit, registered
dout_valid  output  1  dout_serial carries a frame bit, registered
dout_last  output  1  final bit of current frame, registered
dout_chan  output  CHW  channel index of current frame, registered
busy  output  1  high while a frame is being shifted

Behaviour:
- Clock/reset: single clock clk; rst is synchronous, active-high.
- Reset values: dout_serial=0, dout_valid=0, dout_last=0, dout_chan=0, busy=0, state=IDLE, rr pointer=0, bit counter=0, shift register=0.
- States: IDLE, SHIFT.
- Accept window: state==IDLE, or state==SHIFT with the counter on the final bit of the frame.
- Arbitration: in the accept window with any req_valid high, grant the first channel at or after the rr pointer with req_valid high, searching upward with wrap N_CH-1→0.
  - req_ready[g]=1 for the granted channel only; 0 for all others and outside the window.
  - req_ready may depend combinationally on req_valid.
- Handshake: a transfer occurs on an edge where req_valid[g]&req_ready[g]=1. On that edge:
  - shift register ← req_data[g]
  - dout_chan ← g
  - rr pointer ← (g+1) mod N_CH
  - state ← SHIFT, counter ← 0
- Latency: for a handshake at edge k, the bits d[DW-1]..d[0] appear on dout_serial with dout_valid=1 during cycles k+1..k+DW, one bit per cycle.
  - dout_last=1 only in cycle k+DW.
  - busy=1 throughout those cycles.
- Back-to-back frames: a handshake in the last-bit cycle starts the next frame with no idle gap; dout_valid stays 1 continuously.
- End of frame with no handshake in the last-bit cycle: next cycle state=IDLE, dout_valid=0, dout_last=0, dout_serial=0, busy=0. dout_chan holds its last value.
- req_valid deasserted by a channel mid-frame of another channel: no effect. A held req_valid is not required to be stable until granted.
- Outside the accept window: req_ready=0 and req_data is ignored; the captured word is immune to later req_data changes.
- Fairness: a channel holding req_valid continuously is granted within N_CH frames.
- Reset during SHIFT: the frame is aborted. The next cycle shows all outputs at reset values and the pointer at 0; no partial frame resumes.
- Counter width: clog2(DW+1). No arithmetic overflow is possible.

Optional Feature:
- Macro: P2S_PARITY_EN.
- Defined:
  - Frame is DW+1 bits: data MSB-first, then one even-parity bit (XOR of the captured word) in cycle k+DW+1.
  - dout_last marks the parity bit.
  - Accept window is the parity cycle.
- Undefined: frame is exactly DW bits; no parity logic is present.

Test Plan:
- Single request: ch1 valid with 8'hA5 at edge k → req_ready=4'b0010 at k; dout_serial 1,0,1,0,0,1,0,1 in k+1..k+8; dout_chan=1; dout_last only at k+8; dout_valid=0 at k+9.
- Round-robin: all four valid continuously with words 8'h11, 8'h22, 8'h33, 8'h44 → four gapless frames in channel order 0,1,2,3, then 0 again; dout_valid never drops across 32 cycles.
- Pointer wrap: pointer=3 (after ch2 grant), only ch0 and ch1 valid → ch0 granted first, then ch1.
- Data stability: change req_data[ch0] from 8'hFF to 8'h00 two cycles after its grant → serial output still eight 1s.
- Reset mid-frame: assert rst at bit 4 of an 8'hC3 frame → next cycle dout_valid=0, busy=0, dout_chan=0. The next request from ch2 is granted from pointer 0 and its frame is complete.
- P2S_PARITY_EN defined: 8'h07 → nine bits 0,0,0,0,0,1,1,1,1; dout_last on the 9th bit. 8'h03 → parity bit 0.
